seatbelt_chime_ctrl: RTL and testbench

- Sequential controller that drives the cabin warning chime and lamp.
- Computes the warning condition from door, ignition and seat-belt inputs.
- Applies a grace delay, then sequences a bounded number of timed chime bursts before self-muting. The lamp stays lit until the condition clears.
- Sits between the raw switch inputs and the body-electronics output drivers.

---
 rtl/seatbelt_chime_pkg.sv | 25 ++
 rtl/chime_timer.sv | 27 ++
 rtl/seatbelt_chime_ctrl.sv | 133 +++++++++++++
 tb/tb_seatbelt_chime_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seatbelt_chime_pkg.sv
// Shared types, default timing and the warning-condition decode for the seat-belt chime controller.
package seatbelt_chime_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRACE     = 3'd1,
        CHIME_ON  = 3'd2,
        CHIME_OFF = 3'd3,
        MUTED     = 3'd4
    } chime_state_e;

    localparam int DEF_GRACE_CYC  = 8;
    localparam int DEF_ON_CYC     = 4;
    localparam int DEF_OFF_CYC    = 4;
    localparam int DEF_MAX_BURSTS = 3;
    localparam int DEF_CNT_W      = 8;

    // Warn while ignition is on and either the door is open or the belt is unfastened.
    function automatic logic warn_cond(input logic door_close,
                                       input logic ignition,
                                       input logic seat_belt);
        return ignition & (~door_close | ~seat_belt);
    endfunction

endpackage

// File: rtl/chime_timer.sv
// Loadable down-counter shared by all timed states; stops at zero and never wraps.
module chime_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seatbelt_chime_ctrl.sv
// Cabin seat-belt warning controller: grace delay, bounded chime bursts, then self-mute.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// IDLE      | no warning condition; timer and burst count cleared
// GRACE     | condition present, waiting GRACE_CYC cycles before chiming
// CHIME_ON  | chime audible for ON_CYC cycles
// CHIME_OFF | silent gap of OFF_CYC cycles; decides next burst or mute
// MUTED     | all bursts used; silent until the condition clears
module seatbelt_chime_ctrl
    import seatbelt_chime_pkg::*;
#(
    parameter int GRACE_CYC  = DEF_GRACE_CYC,
    parameter int ON_CYC     = DEF_ON_CYC,
    parameter int OFF_CYC    = DEF_OFF_CYC,
    parameter int MAX_BURSTS = DEF_MAX_BURSTS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       door_close,
    input  logic       ignition,
    input  logic       seat_belt,
    output logic       chime,
    output logic       lamp,
    output logic       muted,
    output logic [2:0] state_o
);

    localparam int BW = $clog2(MAX_BURSTS + 1);

    chime_state_e     state, state_nxt;
    logic [BW-1:0]    burst_cnt, burst_nxt;
    logic             w;
    logic             tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    assign w = warn_cond(door_close, ignition, seat_belt);

    chime_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_en    = 1'b0;
        // Losing the condition outranks any timer expiry on the same edge.
        if (state != IDLE && !w) begin
            state_nxt = IDLE;
            burst_nxt = '0;
            tmr_load  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (w) begin
                        state_nxt = GRACE;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(GRACE_CYC - 1);
                    end
                end
                GRACE: begin
                    if (tmr_zero) begin
                        state_nxt = CHIME_ON;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(ON_CYC - 1);
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                CHIME_ON: begin
                    if (tmr_zero) begin
                        state_nxt = CHIME_OFF;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(OFF_CYC - 1);
                        if (burst_cnt != BW'(MAX_BURSTS)) begin
                            burst_nxt = burst_cnt + 1'b1;
                        end
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                CHIME_OFF: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        if (burst_cnt == BW'(MAX_BURSTS)) begin
                            state_nxt = MUTED;
                        end else begin
                            state_nxt = CHIME_ON;
                            tmr_val   = CNT_W'(ON_CYC - 1);
                        end
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                MUTED: begin
                    state_nxt = MUTED;
                end
                default: begin
                    state_nxt = IDLE;
                    burst_nxt = '0;
                    tmr_load  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            chime     <= 1'b0;
            muted     <= 1'b0;
            lamp      <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            chime     <= (state_nxt == CHIME_ON);
            muted     <= (state_nxt == MUTED);
            lamp      <= w;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_seatbelt_chime_ctrl.sv
// Directed self-checking bench for seatbelt_chime_ctrl with default parameters.
module tb_seatbelt_chime_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       door_close = 1'b1;
    logic       ignition = 1'b0;
    logic       seat_belt = 1'b1;
    logic       chime, lamp, muted;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fails  = 0;

    seatbelt_chime_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .door_close (door_close),
        .ignition   (ignition),
        .seat_belt  (seat_belt),
        .chime      (chime),
        .lamp       (lamp),
        .muted      (muted),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ignition   = 1'b0;
        door_close = 1'b1;
        seat_belt  = 1'b1;
        rst_n      = 1'b0;
        #12;
        rst_n = 1'b1;
        tick(1);
    endtask

    // Expected state k edges after the IDLE->GRACE edge, condition held throughout.
    function automatic int exp_state(input int k);
        if (k < 8)  return 1;
        if (k >= 32) return 4;
        return (((k - 8) % 8) < 4) ? 2 : 3;
    endfunction

    // Caller is positioned just after the IDLE->GRACE edge (k = 0).
    task automatic run_seq(input string tag, input int last_k);
        for (int k = 0; k <= last_k; k++) begin
            chk($sformatf("%s_state_k%0d", tag, k), 32'(state_o), 32'(exp_state(k)));
            chk($sformatf("%s_chime_k%0d", tag, k), 32'(chime), 32'(exp_state(k) == 2));
            chk($sformatf("%s_muted_k%0d", tag, k), 32'(muted), 32'(exp_state(k) == 4));
            if (k >= 1) chk($sformatf("%s_lamp_k%0d", tag, k), 32'(lamp), 32'd1);
            if (k < last_k) tick(1);
        end
    endtask

    initial begin
        #3;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_chime", 32'(chime), 32'd0);
        chk("rst_lamp",  32'(lamp),  32'd0);
        chk("rst_muted", 32'(muted), 32'd0);

        // Full sequence, then one-cycle drop from MUTED and a fresh sequence.
        do_reset();
        chk("idle_state", 32'(state_o), 32'd0);
        ignition = 1'b1; seat_belt = 1'b0;
        tick(1);
        run_seq("full", 36);
        seat_belt = 1'b1;
        tick(1);
        chk("drop_state", 32'(state_o), 32'd0);
        chk("drop_muted", 32'(muted), 32'd0);
        seat_belt = 1'b0;
        tick(1);
        run_seq("rearm", 33);

        // Reset asserted mid CHIME_ON.
        do_reset();
        ignition = 1'b1; seat_belt = 1'b0;
        tick(1);
        tick(10);
        chk("pre_rst_chime", 32'(chime), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_chime", 32'(chime), 32'd0);
        chk("async_rst_lamp",  32'(lamp),  32'd0);
        chk("async_rst_muted", 32'(muted), 32'd0);
        chk("async_rst_state", 32'(state_o), 32'd0);
        #2 rst_n = 1'b1;
        tick(1);
        chk("post_rst_grace", 32'(state_o), 32'd1);
        tick(7);
        chk("post_rst_k7_chime", 32'(chime), 32'd0);
        tick(1);
        chk("post_rst_k8_chime", 32'(chime), 32'd1);

        // Belt fastened during GRACE.
        do_reset();
        ignition = 1'b1; seat_belt = 1'b0;
        tick(1);
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk($sformatf("belt_grace_k%0d", k), 32'(state_o), 32'd1);
        end
        seat_belt = 1'b1;
        tick(1);
        chk("belt_idle_state", 32'(state_o), 32'd0);
        chk("belt_lamp_off",   32'(lamp),    32'd0);
        tick(10);
        chk("belt_no_chime",   32'(chime),   32'd0);

        // Ignition off mid second burst, then a new ignition.
        do_reset();
        ignition = 1'b1; seat_belt = 1'b0;
        tick(1);
        tick(17);
        chk("ign_k17_chime", 32'(chime), 32'd1);
        ignition = 1'b0;
        tick(1);
        chk("ign_off_chime", 32'(chime), 32'd0);
        chk("ign_off_state", 32'(state_o), 32'd0);
        chk("ign_off_lamp",  32'(lamp), 32'd0);
        tick(11);
        chk("ign_wait_state", 32'(state_o), 32'd0);
        ignition = 1'b1;
        tick(1);
        chk("ign_new_grace", 32'(state_o), 32'd1);
        tick(7);
        chk("ign_new_k7_chime", 32'(chime), 32'd0);
        tick(1);
        chk("ign_new_k8_chime", 32'(chime), 32'd1);

        // Cause swap: door opens, then belt fastened, condition never drops.
        do_reset();
        ignition = 1'b1; seat_belt = 1'b0; door_close = 1'b1;
        tick(1);
        tick(2);
        door_close = 1'b0;
        tick(2);
        seat_belt = 1'b1;
        tick(3);
        chk("swap_k7_state", 32'(state_o), 32'd1);
        chk("swap_k7_chime", 32'(chime), 32'd0);
        tick(1);
        chk("swap_k8_chime", 32'(chime), 32'd1);
        chk("swap_k8_lamp",  32'(lamp), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
